multicycle_controller: RTL
==========================

# multicycle_controller

Sequencing and decode FSM for the multicycle MIPS subset core. It drives the `state` and `pc` buses that the instruction memory samples, and consumes the 32-bit instruction that memory returns. It decodes that instruction into register fields, a sign-extended immediate and per-state datapath strobes. It also resolves beq/bne from the datapath's equality flag and halts when the PC leaves the program range.

## Interface
- NUM_INSTR, 11: number of valid instruction words; legal PC range is 0..NUM_INSTR-1.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- instruction  in  32  word from instruction memory; valid from state 1 until the next state-0 edge.
- eq  in  1  datapath flag, rs value == rt value; sampled in state 2 only.
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT.
- pc  out  4  current instruction index.
- rs, rt, rd  out  5 each  registered instruction fields.
- imm_sext  out  32  registered sign-extended instruction[15:0].
- alu_op  out  2  0 add, 1 slt, 2 sub/compare.
- alu_src_imm  out  1  ALU B operand is imm_sext.
- reg_dst_rd  out  1  write register is rd (R-type), otherwise rt.
- mem_read  out  1  data-memory read strobe.
- mem_to_reg  out  1  writeback data comes from memory.
- reg_write  out  1  register-file write strobe.
- halted  out  1  sticky; FSM is in HALT.
- illegal  out  1  sticky; halt was caused by an unsupported opcode or funct.

## Operation
- Supported instructions:
  - lw: opcode 0x23.
  - addiu: opcode 0x09.
  - R-type: opcode 0x00 with funct 0x21 (addu) or 0x2A (slt).
  - beq: opcode 0x04.
  - bne: opcode 0x05.
- FETCH (0) goes to DECODE unconditionally. Memory latches instruction[pc] on this edge.
- DECODE (1) latches rs=[25:21], rt=[20:16], rd=[15:11], imm_sext, alu_op, alu_src_imm, reg_dst_rd and mem_to_reg.
  - Next state is EXEC for a supported instruction.
  - Otherwise next state is HALT with illegal=1.
- EXEC (2):
  - lw goes to MEM.
  - addiu and R-type go to WB.
  - Branches resolve here.
    - Taken when (beq & eq) | (bne & ~eq).
    - target = pc + 1 + signed imm, computed in 17-bit signed arithmetic.
    - Not taken: target = pc + 1.
    - If 0 <= target < NUM_INSTR: pc <= target[3:0] and state <= FETCH.
    - Otherwise state <= HALT and pc is held.
- MEM (3): mem_read=1; next state is WB.
- WB (4): reg_write=1.
  - mem_to_reg=1 for lw.
  - pc+1 == NUM_INSTR: go to HALT.
  - Otherwise pc <= pc+1 and go to FETCH.
- HALT (5): absorbing until rst. All strobes are 0; pc and decoded fields are held.
- Strobe decode:
  - alu_op: 1 for slt, 2 for branches, 0 for everything else.
  - alu_src_imm: 1 for lw and addiu.
  - reg_dst_rd: 1 for R-type.
- States 6 and 7 are unreachable. If entered, the next state is HALT with illegal=1.

## Timing
- Reset values:
  - state=0, pc=0.
  - rs=rt=rd=0, imm_sext=0, alu_op=0.
  - All strobes 0; halted=0, illegal=0.
- Cycles per instruction, FETCH through the return to FETCH:
  - R-type and addiu: 4.
  - lw: 5.
  - beq and bne: 3.
- Decoded fields are stable from the first cycle of EXEC until the next DECODE edge.
- mem_read, reg_write and mem_to_reg are combinational from state plus the latched class. Each strobe is high for exactly one cycle per instruction.
- pc changes only on the WB→FETCH or EXEC→FETCH edge. pc is stable throughout FETCH for the memory sample.
- eq is ignored outside EXEC and for non-branch instructions.
- rst asserted in any state, including mid-lw in MEM or in HALT, takes effect on the next edge:
  - State returns to FETCH and pc to 0.
  - No strobe is asserted in the cycle after rst.
- Offset wrap: out-of-range targets in either direction (negative, or >= NUM_INSTR) always halt. The 4-bit pc never wraps.

## Test plan
- Reset and lw: rst high for 2 cycles, then a memory returning 0x8C010000 at pc 0.
  - Required: states 0,1,2,3,4,0.
  - mem_read high only in state 3.
  - reg_write high only in state 4, with rt=1 and mem_to_reg=1.
  - pc=1 on re-entry to FETCH.
- addu at pc 7: instruction 0x00852021.
  - Required: states 0,1,2,4,0.
  - rd=4, reg_dst_rd=1, alu_op=0.
  - pc=8 afterwards.
- bne backward: pc 10, instruction 0x14C0FFFD, eq=0 in EXEC.
  - Required: pc=8 and state 0 after 3 cycles.
  - Repeating with eq=1 gives target 11, which halts: halted=1, state=5, pc=10.
- beq forward out of range: pc 6, instruction 0x10C00005, eq=1.
  - Required: target 12, HALT entered from EXEC, illegal=0.
  - With eq=0: pc=7.
- Illegal opcode: 0xFC000000 at pc 3.
  - Required: DECODE→HALT, illegal=1, halted=1.
  - No strobe ever asserted; state stays at 5 for 10 cycles.
- Mid-operation reset: rst pulsed during MEM of an lw at pc 2.
  - Required: next cycle state=0, pc=0, all strobes 0, halted=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Controller <-> instruction memory / datapath bundle.
// master = controller, slave = memory and datapath side.
interface multicycle_controller_if;
  logic [31:0] instruction;
  logic        eq;
  logic [2:0]  state;
  logic [3:0]  pc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;
  logic [1:0]  alu_op;
  logic        alu_src_imm;
  logic        reg_dst_rd;
  logic        mem_read;
  logic        mem_to_reg;
  logic        reg_write;
  logic        halted;
  logic        illegal;

  modport master (
    input  instruction, eq,
    output state, pc, rs, rt, rd, imm_sext, alu_op, alu_src_imm, reg_dst_rd,
           mem_read, mem_to_reg, reg_write, halted, illegal
  );

  modport slave (
    output instruction, eq,
    input  state, pc, rs, rt, rd, imm_sext, alu_op, alu_src_imm, reg_dst_rd,
           mem_read, mem_to_reg, reg_write, halted, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing and decode FSM for the multicycle MIPS subset core.
// state | meaning: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT (6/7 recover to HALT)
module multicycle_controller #(
  parameter int NUM_INSTR = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_LW, C_ADDIU, C_RTYPE, C_BEQ, C_BNE
  } cls_t;

  state_t      state_q;
  cls_t        cls_q, cls_d;
  logic [3:0]  pc_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [31:0] imm_q, imm_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic        alu_src_imm_q, reg_dst_rd_q;
  logic        halted_q, illegal_q;

  logic [5:0]  opcode, funct;
  assign opcode = bus.instruction[31:26];
  assign funct  = bus.instruction[5:0];
  assign imm_d  = {{16{bus.instruction[15]}}, bus.instruction[15:0]};

  always_comb begin
    cls_d    = C_NONE;
    alu_op_d = 2'd0;
    case (opcode)
      6'h23: cls_d = C_LW;
      6'h09: cls_d = C_ADDIU;
      6'h00: begin
        if (funct == 6'h21) begin
          cls_d = C_RTYPE;
        end else if (funct == 6'h2A) begin
          cls_d    = C_RTYPE;
          alu_op_d = 2'd1;
        end
      end
      6'h04: begin
        cls_d    = C_BEQ;
        alu_op_d = 2'd2;
      end
      6'h05: begin
        cls_d    = C_BNE;
        alu_op_d = 2'd2;
      end
      default: cls_d = C_NONE;
    endcase
  end

  // Branch target kept in 17-bit signed so negative offsets cannot alias into range.
  logic               br_taken, br_ok, wb_last;
  logic signed [16:0] pc_next_s, br_target;
  logic [4:0]         pc_inc;

  assign br_taken  = (cls_q == C_BEQ && bus.eq) || (cls_q == C_BNE && !bus.eq);
  assign pc_next_s = $signed({13'd0, pc_q}) + 17'sd1;
  assign br_target = br_taken ? pc_next_s + $signed(imm_q[16:0]) : pc_next_s;
  assign br_ok     = !br_target[16] && (br_target[15:0] < 16'(NUM_INSTR));
  assign pc_inc    = {1'b0, pc_q} + 5'd1;
  assign wb_last   = (pc_inc == 5'(NUM_INSTR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      cls_q         <= C_NONE;
      pc_q          <= 4'd0;
      rs_q          <= 5'd0;
      rt_q          <= 5'd0;
      rd_q          <= 5'd0;
      imm_q         <= 32'd0;
      alu_op_q      <= 2'd0;
      alu_src_imm_q <= 1'b0;
      reg_dst_rd_q  <= 1'b0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          rs_q          <= bus.instruction[25:21];
          rt_q          <= bus.instruction[20:16];
          rd_q          <= bus.instruction[15:11];
          imm_q         <= imm_d;
          alu_op_q      <= alu_op_d;
          alu_src_imm_q <= (cls_d == C_LW) || (cls_d == C_ADDIU);
          reg_dst_rd_q  <= (cls_d == C_RTYPE);
          cls_q         <= cls_d;
          if (cls_d == C_NONE) begin
            state_q   <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_LW:             state_q <= S_MEM;
            C_ADDIU, C_RTYPE: state_q <= S_WB;
            C_BEQ, C_BNE: begin
              if (br_ok) begin
                pc_q    <= br_target[3:0];
                state_q <= S_FETCH;
              end else begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
              end
            end
            default: begin
              state_q   <= S_HALT;
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEM: state_q <= S_WB;
        S_WB: begin
          if (wb_last) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q    <= pc_inc[3:0];
            state_q <= S_FETCH;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          state_q   <= S_HALT;
          halted_q  <= 1'b1;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.pc          = pc_q;
  assign bus.rs          = rs_q;
  assign bus.rt          = rt_q;
  assign bus.rd          = rd_q;
  assign bus.imm_sext    = imm_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_src_imm = alu_src_imm_q;
  assign bus.reg_dst_rd  = reg_dst_rd_q;
  assign bus.mem_read    = (state_q == S_MEM);
  assign bus.reg_write   = (state_q == S_WB);
  assign bus.mem_to_reg  = (state_q == S_WB) && (cls_q == C_LW);
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;

endmodule
